// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: HS/VS/BLANK/RGB with pixel FIFO fetch and underflow tracking.
// Define VIDEO_TPG_EN to build in the 8-bar colour test pattern selected by tpg_sel.
module video_timing_gen #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned HFP        = 40,
  parameter int unsigned HPULSE     = 48,
  parameter int unsigned HBP        = 40,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned VFP        = 13,
  parameter int unsigned VPULSE     = 3,
  parameter int unsigned VBP        = 29,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned FETCH_LEAD = 1
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  input  logic                     enable,
  output logic                     pix_req,
  input  logic [23:0]              pix_data,
  input  logic                     pix_valid,
  input  logic                     tpg_sel,
  input  logic                     clr_underflow,
  output logic                     HS,
  output logic                     VS,
  output logic                     BLANK,
  output logic [23:0]              RGB,
  output logic [$clog2(HDISP)-1:0] x,
  output logic [$clog2(VDISP)-1:0] y,
  output logic                     frame_start,
  output logic                     line_start,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt
);

  localparam int unsigned HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int unsigned VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);
  localparam int unsigned XW     = $clog2(HDISP);
  localparam int unsigned YW     = $clog2(VDISP);
  localparam int unsigned HSTART = HFP + HPULSE + HBP;
  localparam int unsigned VSTART = VFP + VPULSE + VBP;
  localparam int unsigned CW     = 5 + XW + YW;
  localparam int unsigned FW     = 26;
  localparam int unsigned BAR_W  = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam int          FL     = int'(FETCH_LEAD);
  localparam logic [CW-1:0] CTL_IDLE = {!HS_POL, !VS_POL, {(CW-2){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            run;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic            h_last, v_last, act;
  logic            hs_c, vs_c, fs_c, ls_c;
  logic [XW-1:0]   x_c;
  logic [YW-1:0]   y_c;
  logic            tpg_on_c;
  logic [23:0]     tpg_rgb_c;
  logic [CW-1:0]   ctl_q [FL+1];
  logic [FW-1:0]   fet_q [FL];
  logic [FW-1:0]   fet_c;

  // State register
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next state: stopping is only honoured on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable && h_last && v_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run = 1'b0;
    if (state_q == RUN) run = 1'b1;
  end

  assign h_last = (h == HW'(HTOTAL - 1));
  assign v_last = (v == VW'(VTOTAL - 1));

  // Raster counters, held at the origin while idle
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!run) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    act  = run && (h >= HW'(HSTART)) && (v >= VW'(VSTART));
    hs_c = (run && h >= HW'(HFP) && h < HW'(HFP + HPULSE)) ? HS_POL : !HS_POL;
    vs_c = (run && v >= VW'(VFP) && v < VW'(VFP + VPULSE)) ? VS_POL : !VS_POL;
    fs_c = run && (h == '0) && (v == '0);
    ls_c = run && (h == '0);
    x_c  = act ? XW'(h - HW'(HSTART)) : '0;
    y_c  = act ? YW'(v - VW'(VSTART)) : '0;
  end

`ifdef VIDEO_TPG_EN
  logic          tpg_frame_q;
  logic [XW-1:0] bar_c;

  // Pattern choice is latched once per frame at the origin
  always_comb tpg_on_c = fs_c ? tpg_sel : tpg_frame_q;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) tpg_frame_q <= 1'b0;
    else              tpg_frame_q <= tpg_on_c;
  end

  always_comb begin
    bar_c = x_c / XW'(BAR_W);
    case (bar_c)
      XW'(0):  tpg_rgb_c = 24'hFFFFFF;
      XW'(1):  tpg_rgb_c = 24'hFFFF00;
      XW'(2):  tpg_rgb_c = 24'h00FFFF;
      XW'(3):  tpg_rgb_c = 24'h00FF00;
      XW'(4):  tpg_rgb_c = 24'hFF00FF;
      XW'(5):  tpg_rgb_c = 24'hFF0000;
      XW'(6):  tpg_rgb_c = 24'h0000FF;
      default: tpg_rgb_c = 24'h000000;
    endcase
  end
`else
  logic unused_tpg_sel;
  assign unused_tpg_sel = tpg_sel;
  assign tpg_on_c       = 1'b0;
  assign tpg_rgb_c      = '0;
`endif

  assign pix_req = act && !tpg_on_c;
  assign fet_c   = {act && tpg_on_c, pix_req && pix_valid, tpg_rgb_c};

  // Delay lines: control aligned to RGB, fetch info aligned to returning pix_data
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      for (int i = 0; i <= FL; i++) ctl_q[i] <= CTL_IDLE;
      for (int i = 0; i < FL; i++)  fet_q[i] <= '0;
      RGB <= '0;
    end else begin
      ctl_q[0] <= {hs_c, vs_c, act, fs_c, ls_c, x_c, y_c};
      for (int i = 1; i <= FL; i++) ctl_q[i] <= ctl_q[i-1];
      fet_q[0] <= fet_c;
      for (int i = 1; i < FL; i++)  fet_q[i] <= fet_q[i-1];
      RGB <= fet_q[FL-1][25] ? fet_q[FL-1][23:0] :
             (fet_q[FL-1][24] ? pix_data : 24'h000000);
    end
  end

  assign {HS, VS, BLANK, frame_start, line_start, x, y} = ctl_q[FL];

  // Sticky underflow flag and saturating count; clear beats a same-cycle event
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (clr_underflow) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (pix_req && !pix_valid) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised self-checking bench for video_timing_gen on a 15x8 raster with a frame-position reference model.
module tb_video_timing_gen;

  localparam int H_DISP = 8, H_FP = 2, H_PULSE = 3, H_BP = 2;
  localparam int V_DISP = 4, V_FP = 1, V_PULSE = 2, V_BP = 1;
  localparam int H_TOT = H_FP + H_PULSE + H_BP + H_DISP;
  localparam int V_TOT = V_FP + V_PULSE + V_BP + V_DISP;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam int H_ACT = H_FP + H_PULSE + H_BP;
  localparam int V_ACT = V_FP + V_PULSE + V_BP;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        pix_req;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b1;
  logic        tpg_sel = 1'b0;
  logic        clr_underflow = 1'b0;
  logic        HS, VS, BLANK, frame_start, line_start, underflow;
  logic [23:0] RGB;
  logic [2:0]  x;
  logic [1:0]  y;
  logic [15:0] underflow_cnt;

  video_timing_gen #(
    .HDISP(H_DISP), .HFP(H_FP), .HPULSE(H_PULSE), .HBP(H_BP),
    .VDISP(V_DISP), .VFP(V_FP), .VPULSE(V_PULSE), .VBP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LEAD(1)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(enable),
    .pix_req(pix_req), .pix_data(pix_data), .pix_valid(pix_valid),
    .tpg_sel(tpg_sel), .clr_underflow(clr_underflow),
    .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic hs, vs, blank, fs, ls;
    logic [2:0] x;
    logic [1:0] y;
    logic good;
    logic [23:0] rgb;
  } exp_t;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  exp_t ring [4];
  int   cyc = 4;
  int   n_tests = 0, n_fail = 0;
  int   n_req, n_fs, n_ls, n_blank;
  bit   rand_valid = 0;
  bit   m_run, m_tpg, m_uf;
  int   m_pos, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pos = 0; m_tpg = 0; m_uf = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) ring[i] = idle_e();
  endfunction

  function automatic bit model_req();
    int h = m_pos % H_TOT;
    int v = m_pos / H_TOT;
    return m_run && h >= H_ACT && v >= V_ACT && !m_tpg;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ".HS"}, HS, 1);
    check({tag, ".VS"}, VS, 1);
    check({tag, ".BLANK"}, BLANK, 0);
    check({tag, ".RGB"}, RGB, 0);
    check({tag, ".x"}, x, 0);
    check({tag, ".y"}, y, 0);
    check({tag, ".frame_start"}, frame_start, 0);
    check({tag, ".line_start"}, line_start, 0);
    check({tag, ".underflow"}, underflow, 0);
    check({tag, ".underflow_cnt"}, underflow_cnt, 0);
    check({tag, ".pix_req"}, pix_req, 0);
  endtask

  // One pixel clock: check pins against the entry from two cycles ago, then advance the model
  task automatic step();
    int h, v;
    logic act, req;
    exp_t e, p;
    pix_data = 24'($urandom);
    if (rand_valid) pix_valid = ($urandom_range(0, 3) != 0);
    #1;
    p = ring[(cyc - 1) % 4];
    if (p.good) begin
      p.rgb = pix_data;
      ring[(cyc - 1) % 4] = p;
    end
    e = ring[(cyc - 2) % 4];
    check("HS", HS, e.hs);
    check("VS", VS, e.vs);
    check("BLANK", BLANK, e.blank);
    check("RGB", RGB, e.rgb);
    check("x", x, e.x);
    check("y", y, e.y);
    check("frame_start", frame_start, e.fs);
    check("line_start", line_start, e.ls);
    check("underflow", underflow, m_uf);
    check("underflow_cnt", underflow_cnt, 32'(m_cnt));
    n_req += pix_req; n_fs += frame_start; n_ls += line_start; n_blank += BLANK;

    h = m_pos % H_TOT;
    v = m_pos / H_TOT;
    if (m_run && m_pos == 0) m_tpg = tpg_sel;
    act = m_run && h >= H_ACT && v >= V_ACT;
    req = act && !m_tpg;
    check("pix_req", pix_req, req);
    e = idle_e();
    e.hs    = !(m_run && h >= H_FP && h < H_FP + H_PULSE);
    e.vs    = !(m_run && v >= V_FP && v < V_FP + V_PULSE);
    e.blank = act;
    e.fs    = m_run && m_pos == 0;
    e.ls    = m_run && h == 0;
    e.x     = act ? 3'(h - H_ACT) : 3'd0;
    e.y     = act ? 2'(v - V_ACT) : 2'd0;
    e.good  = req && pix_valid;
    e.rgb   = (act && m_tpg) ? bars[h - H_ACT] : 24'h0;
    ring[cyc % 4] = e;

    @(posedge pixel_clk);
    if (clr_underflow) begin
      m_uf = 0; m_cnt = 0;
    end else if (req && !pix_valid) begin
      m_uf = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == F_TOT - 1 && !enable) begin
      m_run = 0; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % F_TOT;
    end
    @(negedge pixel_clk);
    cyc++;
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    while (!(m_run && m_pos == p) && guard < 3 * F_TOT) begin
      step();
      guard++;
    end
    check("wait_pos_bound", guard < 3 * F_TOT, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int drops, guard;
    model_reset();
    #1 pixel_rst_n = 1'b0;
    #2 check_reset("por");
    repeat (3) @(negedge pixel_clk);
    check_reset("por_held");
    pixel_rst_n = 1'b1;

    // Steady frames with an always-ready FIFO
    enable = 1'b1;
    wait_pos(0);
    n_req = 0; n_fs = 0; n_ls = 0;
    repeat (F_TOT) step();
    check("req_per_frame", n_req, 32);
    check("frame_starts", n_fs, 1);
    check("line_starts", n_ls, V_TOT);

    // Random FIFO starvation with occasional clears
    rand_valid = 1;
    repeat (3 * F_TOT) begin
      clr_underflow = ($urandom_range(0, 19) == 0);
      step();
    end
    clr_underflow = 1'b0; rand_valid = 0; pix_valid = 1'b1;

    // Exactly three starved requests, then clear
    clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
    drops = 0; guard = 0;
    while (drops < 3 && guard < 2 * F_TOT) begin
      if (model_req() && $urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0; drops++;
      end else begin
        pix_valid = 1'b1;
      end
      step();
      guard++;
    end
    check("uf_drop_bound", drops, 3);
    pix_valid = 1'b1;
    repeat (3) step();
    check("uf_flag", underflow, 1);
    check("uf_cnt3", underflow_cnt, 3);
    clr_underflow = 1'b1; step(); clr_underflow = 1'b0; step();
    check("uf_flag_clr", underflow, 0);
    check("uf_cnt_clr", underflow_cnt, 0);

    // Stop request mid-frame completes the frame
    wait_pos(50);
    enable = 1'b0;
    n_req = 0; guard = 0;
    while (m_run && guard < 2 * F_TOT) begin step(); guard++; end
    check("stop_tail_req", n_req, 32);
    repeat (3) step();
    n_req = 0; n_blank = 0;
    repeat (40) step();
    check("idle_req", n_req, 0);
    check("idle_blank", n_blank, 0);

    // Asynchronous reset in the middle of an active line
    enable = 1'b1;
    wait_pos(5 * H_TOT + 10);
    pixel_rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge pixel_clk);
    check_reset("rst_held");
    pixel_rst_n = 1'b1;
    model_reset();
    wait_pos(0);
    n_req = 0;
    repeat (F_TOT) step();
    check("req_after_rst", n_req, 32);

`ifdef VIDEO_TPG_EN
    // Colour bars replace fetched pixels and suppress requests
    tpg_sel = 1'b1; rand_valid = 1;
    wait_pos(1);
    n_req = 0;
    repeat (F_TOT) step();
    check("tpg_req", n_req, 0);
    check("tpg_uf", underflow_cnt, 0);
    tpg_sel = 1'b0;
    repeat (2 * F_TOT) step();
    rand_valid = 0; pix_valid = 1'b1;
`endif

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised successor of the fixed 800x480 VGA timing generator. Produces HS/VS/BLANK/RGB for any resolution, porch set and sync polarity, and issues pixel read requests to an upstream pixel FIFO with programmable read latency. It adds run/stop control on frame boundaries, active-pixel coordinates, frame/line strobes and underflow detection. It sits between the SDRAM-fed async FIFO and the video_if pins.

Parameters:
HDISP, 800, active pixels per line
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width (pixels)
HBP, 40, horizontal back porch (pixels)
VDISP, 480, active lines per frame
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width (lines)
VBP, 29, vertical back porch (lines)
HS_POL, 0, HS level during the sync pulse
VS_POL, 0, VS level during the sync pulse
FETCH_LEAD, 1, cycles from pix_req to valid pix_data (range 1..4)

Ports:
pixel_clk  in  1  pixel clock
pixel_rst_n  in  1  asynchronous active-low reset
enable  in  1  run request, sampled at frame end
pix_req  out  1  FIFO read strobe
pix_data  in  24  FIFO data, valid FETCH_LEAD cycles after pix_req
pix_valid  in  1  FIFO not empty, sampled with pix_req
tpg_sel  in  1  test-pattern select (see Optional Feature)
clr_underflow  in  1  clears underflow and underflow_cnt
HS  out  1  horizontal sync
VS  out  1  vertical sync
BLANK  out  1  high during active video
RGB  out  24  pixel colour
x  out  $clog2(HDISP)  active column, aligned with RGB
y  out  $clog2(VDISP)  active row, aligned with RGB
frame_start  out  1  one-cycle pulse at output position (0,0)
line_start  out  1  one-cycle pulse at output position h=0
underflow  out  1  sticky underflow flag
underflow_cnt  out  16  saturating underflow count

Behaviour:
- Clock and reset: one clock, pixel_clk. Reset pixel_rst_n is asynchronous and active-low.
- Totals: HTOTAL = HFP+HPULSE+HBP+HDISP and VTOTAL = VFP+VPULSE+VBP+VDISP. Counter h runs 0..HTOTAL-1 and v runs 0..VTOTAL-1, with widths $clog2(HTOTAL) and $clog2(VTOTAL).
- Region order per line and per frame: front porch, sync, back porch, active. Sync is h in [HFP, HFP+HPULSE) and v in [VFP, VFP+VPULSE). Active is h >= HFP+HPULSE+HBP and v >= VFP+VPULSE+VBP.
- Counter stepping: h increments every RUN cycle and wraps HTOTAL-1 -> 0. v increments on h wrap and wraps VTOTAL-1 -> 0.
- FSM states are IDLE and RUN.
- Reset state: IDLE with h=v=0. Outputs: HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, x=y=0, pix_req=0, strobes=0, underflow=0, underflow_cnt=0.
- IDLE -> RUN when enable=1. Counting starts from (0,0) the next cycle.
- RUN -> IDLE only when enable=0 at h=HTOTAL-1 and v=VTOTAL-1. Deasserting enable mid-frame completes the frame.
- pix_req is combinational: it is high in RUN whenever (h,v) is active. Exactly HDISP requests are issued per active line.
- Output alignment: HS, VS, BLANK, x, y and strobes are registered through a delay of FETCH_LEAD+1 stages, so they align with RGB. Total latency from counter to pins is FETCH_LEAD+1 cycles.
- RGB is registered from pix_data. It is 0 when BLANK=0.
- Underflow: pix_valid=0 with pix_req=1 is an underflow.
  - The corresponding output pixel is RGB=0.
  - underflow is set and underflow_cnt increments, saturating at 16'hFFFF.
  - The request still counts as a pixel: no re-timing and no skipping.
- clr_underflow clears both underflow and underflow_cnt. If clr_underflow coincides with a new underflow, the clear wins and the event is lost.
- Entering IDLE flushes the delay line: outputs reach their inactive values FETCH_LEAD+1 cycles after the last RUN cycle.
- Asserting reset mid-frame takes effect immediately, asynchronously. No partial pix_req pulse persists.

Optional Feature:
VIDEO_TPG_EN defined:
- With tpg_sel=1, sampled at frame start, the whole frame shows 8 vertical colour bars. Each bar is HDISP/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black (FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000).
- While a TPG frame is shown, pix_req is held 0 and no underflow is recorded.
VIDEO_TPG_EN undefined:
- tpg_sel is ignored and the TPG logic is absent.

Test Plan:
Bench params HDISP=8, HFP=2, HPULSE=3, HBP=2, VDISP=4, VFP=1, VPULSE=2, VBP=1, FETCH_LEAD=1, which gives 15x8 = 120 cycles per frame.
- Reset, enable=1, pix_valid=1, pix_data=x-index -> HS low for 3 cycles every 15. VS low for lines 1-2. BLANK high for 8 cycles on lines 4-7. Outputs appear 2 cycles after the counter. RGB equals x.
- Count pix_req over one frame -> exactly 32. frame_start pulses once per 120 cycles. line_start pulses every 15 cycles.
- Drop enable at cycle 50 of a frame -> frame completes to cycle 119, then IDLE. Outputs are inactive 2 cycles later and no further pix_req occurs.
- Hold pix_valid=0 for 3 active requests -> those 3 RGB pixels are 0, underflow=1 and underflow_cnt=3. clr_underflow then returns both to 0.
- Pulse pixel_rst_n low mid-line -> all outputs go to reset values immediately without a clock edge. Restart with enable gives a clean frame from (0,0).
- With VIDEO_TPG_EN defined and tpg_sel=1 -> bars 1 pixel wide: RGB FFFFFF, FFFF00, ..., 000000 across each line, and pix_req stays 0.
